// File: rtl/mouse_tracker_if.sv
// Byte stream from the PS/2 receiver into the tracker, plus the tracker's
// cursor/button outputs toward the rope block.
interface mouse_tracker_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] out_mouse_x;
    logic [9:0] out_mouse_y;
    logic [2:0] buttons;
    logic       pos_valid;
    logic       sync_error;

    modport master (
        output rx_data, rx_valid,
        input  out_mouse_x, out_mouse_y, buttons, pos_valid, sync_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output out_mouse_x, out_mouse_y, buttons, pos_valid, sync_error
    );
endinterface

// File: rtl/mouse_tracker.sv
// Assembles 3-byte PS/2 movement packets and accumulates the deltas into a
// clamped absolute cursor position with button state.
module mouse_tracker #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned INIT_X   = 320,
    parameter int unsigned INIT_Y   = 240,
    parameter int unsigned TIMEOUT  = 50000
) (
    input logic            clk,
    input logic            reset,
    mouse_tracker_if.slave bus
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0]   IdleMax = CntW'(TIMEOUT - 1);
    localparam logic signed [11:0] XMax   = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] YMax   = 12'(SCREEN_H - 1);

    typedef enum logic [1:0] {StWaitB0, StWaitB1, StWaitB2} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] idle_q, idle_d;
    // {y_ovf, x_ovf, y_sign, x_sign, m, r, l}; the always-1 bit is not kept
    logic [6:0]      hdr_q, hdr_d;
    logic [7:0]      dx_q, dx_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [2:0]      btn_q, btn_d;
    logic            pos_valid_q, pos_valid_d;
    logic            sync_error_q, sync_error_d;

    logic signed [11:0] x_sum, y_sum;
    logic [9:0]         x_clamp, y_clamp;

    // Screen y grows downward while PS/2 dy is up-positive, hence the subtract.
    assign x_sum = $signed({2'b00, x_q}) + $signed({{3{hdr_q[3]}}, hdr_q[3], dx_q});
    assign y_sum = $signed({2'b00, y_q}) - $signed({{3{hdr_q[4]}}, hdr_q[4], bus.rx_data});

    always_comb begin
        x_clamp = x_sum[9:0];
        if (x_sum < 12'sd0) begin
            x_clamp = '0;
        end else if (x_sum > XMax) begin
            x_clamp = XMax[9:0];
        end
        y_clamp = y_sum[9:0];
        if (y_sum < 12'sd0) begin
            y_clamp = '0;
        end else if (y_sum > YMax) begin
            y_clamp = YMax[9:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        idle_d       = idle_q;
        hdr_d        = hdr_q;
        dx_d         = dx_q;
        x_d          = x_q;
        y_d          = y_q;
        btn_d        = btn_q;
        pos_valid_d  = 1'b0;
        sync_error_d = 1'b0;
        if (bus.rx_valid) begin
            // An arriving byte beats a simultaneous timeout expiry.
            idle_d = '0;
            unique case (state_q)
                StWaitB0: begin
                    if (bus.rx_data[3]) begin
                        hdr_d   = {bus.rx_data[7:4], bus.rx_data[2:0]};
                        state_d = StWaitB1;
                    end else begin
                        sync_error_d = 1'b1;
                    end
                end
                StWaitB1: begin
                    dx_d    = bus.rx_data;
                    state_d = StWaitB2;
                end
                StWaitB2: begin
                    btn_d       = hdr_q[2:0];
                    x_d         = hdr_q[5] ? x_q : x_clamp;
                    y_d         = hdr_q[6] ? y_q : y_clamp;
                    pos_valid_d = 1'b1;
                    state_d     = StWaitB0;
                end
                default: state_d = StWaitB0;
            endcase
        end else if (state_q != StWaitB0) begin
            if (idle_q == IdleMax) begin
                state_d      = StWaitB0;
                idle_d       = '0;
                sync_error_d = 1'b1;
            end else begin
                idle_d = idle_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StWaitB0;
            idle_q       <= '0;
            hdr_q        <= '0;
            dx_q         <= '0;
            x_q          <= 10'(INIT_X);
            y_q          <= 10'(INIT_Y);
            btn_q        <= '0;
            pos_valid_q  <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            hdr_q        <= hdr_d;
            dx_q         <= dx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            btn_q        <= btn_d;
            pos_valid_q  <= pos_valid_d;
            sync_error_q <= sync_error_d;
        end
    end

    assign bus.out_mouse_x = x_q;
    assign bus.out_mouse_y = y_q;
    assign bus.buttons     = btn_q;
    assign bus.pos_valid   = pos_valid_q;
    assign bus.sync_error  = sync_error_q;
endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboarded bench for mouse_tracker: packets push an expected cursor
// state, each pos_valid pulse pops and compares it.
module tb_mouse_tracker;
    localparam int unsigned T = 16;

    typedef struct {
        int x;
        int y;
        int b;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pv_cnt = 0;
    int   se_cnt = 0;
    int   model_x, model_y, model_b;
    exp_t sb_q[$];

    mouse_tracker_if bus();

    mouse_tracker #(
        .TIMEOUT(T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.sync_error) se_cnt++;
            if (bus.pos_valid) begin
                exp_t e;
                pv_cnt++;
                if (sb_q.size() == 0) begin
                    check("pv_unexpected", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("pkt_x", int'(bus.out_mouse_x), e.x);
                    check("pkt_y", int'(bus.out_mouse_y), e.y);
                    check("pkt_btn", int'(bus.buttons), e.b);
                end
            end
        end
    end

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Callers start at posedge+1; each byte is sampled by the next posedge.
    task automatic drive(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        exp_t e;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (!b0[6]) model_x = clampi(model_x + dx, 639);
        if (!b0[7]) model_y = clampi(model_y - dy, 479);
        model_b = int'(b0[2:0]);
        e.x = model_x;
        e.y = model_y;
        e.b = model_b;
        sb_q.push_back(e);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        expect_pkt(b0, b1, b2);
        drive(b0);
        drive(b1);
        drive(b2);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_x = 320;
        model_y = 240;
        model_b = 0;
        @(negedge clk);
        check("rst_x", int'(bus.out_mouse_x), 320);
        check("rst_y", int'(bus.out_mouse_y), 240);
        check("rst_btn", int'(bus.buttons), 0);
        check("rst_pv", int'(bus.pos_valid), 0);
        check("rst_se", int'(bus.sync_error), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
    endtask

    initial begin
        int pv0, se0;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Basic packet, pulse timing and hold
        pv0 = pv_cnt;
        send_pkt(8'h08, 8'h10, 8'h00);
        check("pv_next_cycle", int'(bus.pos_valid), 1);
        idle(1);
        check("pv_one_cycle", int'(bus.pos_valid), 0);
        idle(3);
        check("pv_count_basic", pv_cnt - pv0, 1);
        check("hold_x", int'(bus.out_mouse_x), 336);

        do_reset();
        send_pkt(8'h29, 8'h00, 8'hF0);
        idle(2);
        check("dy_neg_y", int'(bus.out_mouse_y), 256);

        // Clamping, including back-to-back packets
        do_reset();
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h38, 8'h00, 8'h00);
        send_pkt(8'h38, 8'h00, 8'h00);
        idle(2);
        check("clamp_y", int'(bus.out_mouse_y), 479);

        // Overflow bit freezes x
        do_reset();
        pv0 = pv_cnt;
        send_pkt(8'h4A, 8'h50, 8'h00);
        idle(2);
        check("ovf_pv", pv_cnt - pv0, 1);

        // Resync on a byte without the always-1 bit
        do_reset();
        se0 = se_cnt;
        drive(8'h00);
        idle(3);
        check("resync_se", se_cnt - se0, 1);
        check("resync_x", int'(bus.out_mouse_x), 320);
        send_pkt(8'h08, 8'h10, 8'h00);
        idle(2);

        // Timeout drops the partial packet
        do_reset();
        se0 = se_cnt;
        pv0 = pv_cnt;
        drive(8'h08);
        drive(8'h10);
        idle(T - 1);
        check("to_early_se", se_cnt - se0, 0);
        idle(1);
        check("to_se_pulse", int'(bus.sync_error), 1);
        idle(2);
        check("to_se_count", se_cnt - se0, 1);
        check("to_no_pv", pv_cnt - pv0, 0);
        send_pkt(8'h09, 8'h01, 8'h00);
        idle(2);
        check("to_after_x", int'(bus.out_mouse_x), 321);

        // Byte arriving exactly at expiry completes the packet
        se0 = se_cnt;
        pv0 = pv_cnt;
        expect_pkt(8'h08, 8'h10, 8'h00);
        drive(8'h08);
        drive(8'h10);
        idle(T - 1);
        drive(8'h00);
        idle(3);
        check("expiry_no_se", se_cnt - se0, 0);
        check("expiry_pv", pv_cnt - pv0, 1);

        // Reset mid-packet discards the partial packet
        send_pkt(8'h09, 8'h20, 8'h00);
        idle(2);
        drive(8'h08);
        drive(8'h10);
        do_reset();
        send_pkt(8'h08, 8'hFF, 8'h00);
        idle(2);
        check("post_rst_x", int'(bus.out_mouse_x), 575);

        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mouse_tracker.md
# mouse_tracker

Produces the absolute cursor position that drives the rope's `in_mouse_x` / `in_mouse_y` inputs. It consumes already-deserialized PS/2 mouse bytes from the byte receiver and assembles them into standard 3-byte movement packets. It accumulates the signed deltas into clamped 10-bit screen coordinates and reports button state. It sits between the PS/2 byte receiver and the rope block.

## Interface
- `SCREEN_W`, default 640: x range is 0..SCREEN_W-1.
- `SCREEN_H`, default 480: y range is 0..SCREEN_H-1.
- `INIT_X`, default 320: x position after reset.
- `INIT_Y`, default 240: y position after reset.
- `TIMEOUT`, default 50000: idle clk cycles allowed mid-packet before the tracker resynchronizes.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `rx_data`  input  8  received PS/2 byte.
- `rx_valid`  input  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `out_mouse_x`  output  10  cursor x, unsigned pixels.
- `out_mouse_y`  output  10  cursor y, unsigned pixels; 0 is the top row.
- `buttons`  output  3  {middle, right, left}, active-high.
- `pos_valid`  output  1  one-cycle pulse when a complete packet has been applied.
- `sync_error`  output  1  one-cycle pulse when a byte is discarded or a packet is aborted.

## Operation
- Packet format:
  - Byte0: b7 = Y overflow, b6 = X overflow, b5 = Y sign, b4 = X sign, b3 = always 1, b2..0 = {M, R, L}.
  - Byte1: dx[7:0].
  - Byte2: dy[7:0].
  - dx = {Xsign, byte1} and dy = {Ysign, byte2}, each 9-bit two's complement (-256..+255).
- FSM has three states: WAIT_B0, WAIT_B1, WAIT_B2.
  - WAIT_B0, rx_valid with b3 = 1: latch byte0, go to WAIT_B1.
  - WAIT_B0, rx_valid with b3 = 0: discard the byte, pulse `sync_error`, stay in WAIT_B0.
  - WAIT_B1, rx_valid: latch dx low byte, go to WAIT_B2.
  - WAIT_B2, rx_valid: apply the packet, pulse `pos_valid`, go to WAIT_B0.
- Applying a packet:
  - `buttons` <= byte0[2:0], always.
  - If the X overflow bit is set, x is unchanged; otherwise x_new = clamp(x + dx, 0, SCREEN_W-1).
  - If the Y overflow bit is set, y is unchanged; otherwise y_new = clamp(y - dy, 0, SCREEN_H-1). The subtraction converts PS/2 up-positive to screen down-positive.
  - Use at least 12-bit signed intermediates; the result of clamping always fits in 10 bits.
- Timeout:
  - An idle counter clears on every accepted byte and counts only in WAIT_B1 and WAIT_B2.
  - When it reaches TIMEOUT-1 with no rx_valid: go to WAIT_B0, pulse `sync_error`, drop the partial packet. Outputs are unchanged.
- Simultaneous events:
  - rx_valid in the same cycle as timeout expiry: the byte wins. It is processed as the next byte in sequence and the counter clears.
  - rx_valid is ignored in the cycle `reset` is low.
- Reset, including mid-packet: FSM to WAIT_B0, counter cleared, and the partial packet discarded.

## Timing
- Reset values:
  - `out_mouse_x` = INIT_X
  - `out_mouse_y` = INIT_Y
  - `buttons` = 0
  - `pos_valid` = 0
  - `sync_error` = 0
- All outputs are registered.
- Packet latency:
  - `out_mouse_x`, `out_mouse_y`, and `buttons` take their new values at the rising edge that samples byte2 with rx_valid high.
  - `pos_valid` is high for exactly the following cycle.
- `sync_error` is high for exactly one cycle after the edge that discards a byte or detects the timeout.
- Throughput: one byte per cycle. Back-to-back rx_valid is legal, and a new byte0 may arrive in the cycle after byte2.
- Outputs hold their values between packets. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then bytes 0x08, 0x10, 0x00 back-to-back -> x = 336, y = 240, buttons = 0, one `pos_valid` pulse the cycle after byte2.
- Bytes 0x29, 0x00, 0xF0 (dy = -16, L pressed) -> y = 256, x = 320, buttons = 3'b001.
- Clamp: packet 0x08, 0xFF, 0x00 sent twice from reset -> x = 575, then x = 639. Packet 0x38, 0x00, 0x00 sent twice (dy = -256) -> y = 479 after the first, 479 after the second.
- Overflow: bytes 0x4A, 0x50, 0x00 -> x remains 320, buttons = 3'b010, `pos_valid` pulses.
- Resync: byte 0x00 in WAIT_B0 -> one `sync_error` pulse and no state change; then 0x08, 0x10, 0x00 -> x = 336.
- Timeout: bytes 0x08, 0x10, then TIMEOUT idle cycles -> `sync_error` pulses and there is no `pos_valid`. Next 0x09, 0x01, 0x00 -> x = 321, L = 1. Repeat with rx_valid arriving exactly at expiry -> the byte completes the packet and no `sync_error`. Assert reset mid-packet -> all outputs return to their reset values.
